pat_multi_fsm: RTL

Parametrised paddle-control sequencer for the ping-pong game: drives NUM_PAT paddle channels through initialise / per-frame fetch / update cycles. Sits between the game top FSM (start/brk) and the per-paddle location registers and sensor-fetch interface. Adds over the single-paddle controller: a frame-rate divider, a fetch_req/fetch_ack handshake with timeout, round-robin channel sequencing, a pause mode and sticky per-channel timeout flags.

---
 rtl/pat_pkg.sv | 20 ++
 rtl/pat_multi_fsm_if.sv | 13 +
 rtl/pat_cycle_cnt.sv | 36 +++
 rtl/pat_multi_fsm.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pat_pkg.sv
// Shared definitions for the paddle (pat) blocks: sequencer state codes and
// width helpers reused by the location and display logic.
package pat_pkg;

  localparam int NUM_PAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_INIT   = 3'd1,
    ST_TICK   = 3'd2,
    ST_FETCH  = 3'd3,
    ST_UPDATE = 3'd4
  } pat_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pat_multi_fsm_if.sv
// Sensor-fetch handshake between the paddle sequencer and the sensor front end.
interface pat_multi_fsm_if #(
  parameter int IDX_W = 1
);

  logic             fetch_req;
  logic             fetch_ack;
  logic [IDX_W-1:0] chan_idx;

  modport master (output fetch_req, output chan_idx, input fetch_ack);
  modport slave  (input fetch_req, input chan_idx, output fetch_ack);

endinterface

// File: rtl/pat_cycle_cnt.sv
// Free-running cycle counter with clear, enable and terminal-count flag.
module pat_cycle_cnt #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Clear dominates enable so a terminal hit can restart in the same cycle.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tc = (count_reg == WIDTH'(TERMINAL));

endmodule

// File: rtl/pat_multi_fsm.sv
// Multi-paddle sequencer: frame divider, round-robin sensor fetch with timeout,
// per-channel update strobes and sticky timeout flags.
module pat_multi_fsm
  import pat_pkg::*;
#(
  parameter int NUM_PAT  = NUM_PAT_DEF,
  parameter int IDX_W    = idx_w(NUM_PAT),
  parameter int TICK_DIV = 50000,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 brk,
  input  logic                 pause,
  pat_multi_fsm_if.master      fetch_if,
  output logic [NUM_PAT-1:0]   init_pat,
  output logic [NUM_PAT-1:0]   update_pat,
  output logic                 halt,
  output logic [NUM_PAT-1:0]   err_timeout
);

  localparam int FRAME_W = idx_w(TICK_DIV);
  localparam int TMO_W   = idx_w(TIMEOUT);

  pat_state_e         state_reg, state_next;
  logic               ok_reg, ok_next;
  logic [IDX_W-1:0]   chan_reg, chan_next;
  logic [NUM_PAT-1:0] err_reg, err_next;

  logic frame_clr, frame_en, frame_tc;
  logic tmo_clr, tmo_en, tmo_tc;

  // Frame counter only lives in TICK; it restarts on its own terminal hit.
  assign frame_en  = (state_reg == ST_TICK) && !pause;
  assign frame_clr = (state_reg != ST_TICK) || (frame_en && frame_tc);
  assign tmo_en    = (state_reg == ST_FETCH);
  assign tmo_clr   = (state_reg != ST_FETCH);

  pat_cycle_cnt #(
    .WIDTH    (FRAME_W),
    .TERMINAL (TICK_DIV - 1)
  ) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (frame_clr),
    .en    (frame_en),
    .tc    (frame_tc)
  );

  pat_cycle_cnt #(
    .WIDTH    (TMO_W),
    .TERMINAL (TIMEOUT - 1)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_WAIT;
      ok_reg    <= 1'b0;
      chan_reg  <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ok_reg    <= ok_next;
      chan_reg  <= chan_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ok_next    = ok_reg;
    chan_next  = chan_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_WAIT: begin
        if (start) state_next = ST_INIT;
      end
      ST_INIT: begin
        state_next = ST_TICK;
        chan_next  = '0;
        err_next   = '0;
      end
      ST_TICK: begin
        if (brk) begin
          state_next = ST_WAIT;
        end else if (frame_en && frame_tc) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (brk) begin
          state_next = ST_WAIT;
        end else if (fetch_if.fetch_ack) begin
          state_next = ST_UPDATE;
          ok_next    = 1'b1;
        end else if (tmo_tc) begin
          state_next         = ST_UPDATE;
          ok_next            = 1'b0;
          err_next[chan_reg] = 1'b1;
        end
      end
      ST_UPDATE: begin
        // The strobe for this channel is already on the outputs this cycle.
        if (brk) begin
          state_next = ST_WAIT;
        end else if (chan_reg != IDX_W'(NUM_PAT - 1)) begin
          state_next = ST_FETCH;
          chan_next  = chan_reg + IDX_W'(1);
        end else begin
          state_next = ST_TICK;
          chan_next  = '0;
        end
      end
      default: state_next = ST_WAIT;
    endcase
  end

  assign halt               = (state_reg == ST_WAIT);
  assign init_pat           = {NUM_PAT{state_reg == ST_INIT}};
  assign fetch_if.fetch_req = (state_reg == ST_FETCH);
  assign fetch_if.chan_idx  = chan_reg;
  assign err_timeout        = err_reg;

  for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_update
    assign update_pat[gi] = (state_reg == ST_UPDATE) && ok_reg &&
                            (chan_reg == IDX_W'(gi));
  end

endmodule
